// File: rtl/bram_lane_accumulator.sv
// bram_lane_accumulator
//
// Streams run_count rows out of a source BRAM (BRAM0), adds each row's
// LANES packed inputs into one running sum per lane, and writes the running
// sums after every row as one packed word into a destination BRAM (BRAM1).
// Lane inputs can be signed or unsigned, sums can wrap or saturate, and the
// per-lane sums may be carried over from one run into the next.
//
// Ports:
//   clk, reset_n         clock (rising edge) and synchronous active-low reset
//   start_run_i          start request, only honoured while idle
//   run_count_i          number of rows to process (0 = finish immediately)
//   src_base_i           first BRAM0 row address
//   dst_base_i           first BRAM1 row address
//   acc_clear_i          1 = start from zero sums, 0 = continue previous sums
//   signed_i             1 = lane inputs are two's complement
//   sat_mode_i           1 = saturate at the accumulator limits, 0 = wrap
//   q_b0_i               BRAM0 read data (1-cycle latency), lane 0 in LSBs
//   idle_o, done_o       idle indicator and one-cycle completion pulse
//   read_o, write_o      BRAM0 read / BRAM1 write issued this cycle
//   ovf_o                sticky overflow/saturation flag for the current run
//   addr_b0_o .. d_b0_o  BRAM0 port (read only; write side tied off)
//   addr_b1_o .. d_b1_o  BRAM1 port (write only), lane 0 sum in LSBs
//
// Timing (S = cycle in which start is sampled, N = run_count):
//   reads in S+1..S+N, writes in S+3..S+N+2, done_o in S+N+3, idle in S+N+4.

module bram_lane_accumulator #(
    parameter int LANES   = 4,
    parameter int IN_W    = 8,
    parameter int ACC_W   = 32,
    parameter int AWIDTH  = 8,
    parameter int CNT_BIT = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_run_i,
    input  logic [CNT_BIT-1:0]       run_count_i,
    input  logic [AWIDTH-1:0]        src_base_i,
    input  logic [AWIDTH-1:0]        dst_base_i,
    input  logic                     acc_clear_i,
    input  logic                     signed_i,
    input  logic                     sat_mode_i,
    input  logic [LANES*IN_W-1:0]    q_b0_i,
    output logic                     idle_o,
    output logic                     read_o,
    output logic                     write_o,
    output logic                     done_o,
    output logic                     ovf_o,
    output logic [AWIDTH-1:0]        addr_b0_o,
    output logic                     ce_b0_o,
    output logic                     we_b0_o,
    output logic [LANES*IN_W-1:0]    d_b0_o,
    output logic [AWIDTH-1:0]        addr_b1_o,
    output logic                     ce_b1_o,
    output logic                     we_b1_o,
    output logic [LANES*ACC_W-1:0]   d_b1_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AWIDTH-1:0]  ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_BIT-1:0] CNT_ONE  = {{(CNT_BIT-1){1'b0}}, 1'b1};
    localparam logic [CNT_BIT-1:0] CNT_ZERO = {CNT_BIT{1'b0}};

    // One lane addition: both operands are widened by one bit so that the
    // true result always fits; the extra bit then tells us about overflow.
    // Returns {overflow, result}.
    function automatic logic [ACC_W:0] lane_add(
        input logic [ACC_W-1:0] acc,
        input logic [IN_W-1:0]  din,
        input logic             sgn,
        input logic             sat
    );
        logic [ACC_W:0]   acc_ext;
        logic [ACC_W:0]   din_ext;
        logic [ACC_W:0]   raw;
        logic             ovf;
        logic [ACC_W-1:0] res;
        if (sgn) begin
            acc_ext = {acc[ACC_W-1], acc};
            din_ext = {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};
        end else begin
            acc_ext = {1'b0, acc};
            din_ext = {{(ACC_W+1-IN_W){1'b0}}, din};
        end
        raw = acc_ext + din_ext;
        // Signed: the two top bits disagree when the result left the ACC_W
        // range; raw[ACC_W] is then the true sign. Unsigned: plain carry-out.
        if (sgn) begin
            ovf = raw[ACC_W] ^ raw[ACC_W-1];
        end else begin
            ovf = raw[ACC_W];
        end
        if (ovf && sat) begin
            if (sgn) begin
                res = raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                res = {ACC_W{1'b1}};
            end
        end else begin
            res = raw[ACC_W-1:0];
        end
        return {ovf, res};
    endfunction

    state_t                   state_r;
    state_t                   next_state_s;
    logic                     accept_s;
    logic                     idle_s;
    logic                     done_s;
    logic                     ce_b0_s;

    logic [CNT_BIT-1:0]       rows_left_r;
    logic                     drain_cnt_r;
    logic                     signed_r;
    logic                     sat_r;
    logic [AWIDTH-1:0]        addr_b0_r;
    logic [AWIDTH-1:0]        wr_addr_r;
    logic                     q_valid_r;
    logic [LANES*ACC_W-1:0]   acc_r;
    logic                     ovf_r;

    logic                     idle_r;
    logic                     done_r;
    logic                     ce_b0_r;
    logic                     ce_b1_r;
    logic [AWIDTH-1:0]        addr_b1_r;
    logic [LANES*ACC_W-1:0]   d_b1_r;

    logic [LANES*ACC_W-1:0]   sum_s;
    logic                     add_ovf_s;
    logic [ACC_W:0]           lane_res_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a start is only accepted while idle.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_run_i) begin
                    accept_s = 1'b1;
                    if (run_count_i != CNT_ZERO) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rows_left_r == CNT_ONE) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        idle_s  = 1'b0;
        done_s  = 1'b0;
        ce_b0_s = 1'b0;
        case (next_state_s)
            ST_IDLE:  idle_s  = 1'b1;
            ST_RUN:   ce_b0_s = 1'b1;
            ST_DRAIN: ce_b0_s = 1'b0;
            ST_DONE:  done_s  = 1'b1;
            default:  idle_s  = 1'b0;
        endcase
    end

    // Registered FSM status and BRAM0 enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_r  <= 1'b1;
            done_r  <= 1'b0;
            ce_b0_r <= 1'b0;
        end else begin
            idle_r  <= idle_s;
            done_r  <= done_s;
            ce_b0_r <= ce_b0_s;
        end
    end

    // Run bookkeeping: rows still to read, read address, latched modes and
    // the two-cycle drain timer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rows_left_r <= CNT_ZERO;
            addr_b0_r   <= {AWIDTH{1'b0}};
            signed_r    <= 1'b0;
            sat_r       <= 1'b0;
            drain_cnt_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        rows_left_r <= run_count_i;
                        addr_b0_r   <= src_base_i;
                        signed_r    <= signed_i;
                        sat_r       <= sat_mode_i;
                    end
                end
                ST_RUN: begin
                    rows_left_r <= rows_left_r - CNT_ONE;
                    addr_b0_r   <= addr_b0_r + ADDR_ONE;
                    drain_cnt_r <= 1'b0;
                end
                ST_DRAIN: begin
                    drain_cnt_r <= 1'b1;
                end
                default: begin
                    drain_cnt_r <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane sums of the current BRAM0 row into the accumulators.
    always_comb begin
        sum_s      = {(LANES*ACC_W){1'b0}};
        add_ovf_s  = 1'b0;
        lane_res_s = {(ACC_W+1){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            lane_res_s = lane_add(acc_r[i*ACC_W +: ACC_W], q_b0_i[i*IN_W +: IN_W],
                                  signed_r, sat_r);
            sum_s[i*ACC_W +: ACC_W] = lane_res_s[ACC_W-1:0];
            add_ovf_s = add_ovf_s | lane_res_s[ACC_W];
        end
    end

    // Accumulate the row returned by BRAM0 (one cycle after its read) and
    // issue the matching BRAM1 write on the following cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_valid_r <= 1'b0;
            acc_r     <= {(LANES*ACC_W){1'b0}};
            ovf_r     <= 1'b0;
            wr_addr_r <= {AWIDTH{1'b0}};
            ce_b1_r   <= 1'b0;
            addr_b1_r <= {AWIDTH{1'b0}};
            d_b1_r    <= {(LANES*ACC_W){1'b0}};
        end else begin
            q_valid_r <= ce_b0_r;
            if (accept_s) begin
                wr_addr_r <= dst_base_i;
                ovf_r     <= 1'b0;
                ce_b1_r   <= 1'b0;
                // A zero-count run leaves the sums alone even with clear set.
                if (acc_clear_i && (run_count_i != CNT_ZERO)) begin
                    acc_r <= {(LANES*ACC_W){1'b0}};
                end
            end else if (q_valid_r) begin
                acc_r     <= sum_s;
                d_b1_r    <= sum_s;
                addr_b1_r <= wr_addr_r;
                wr_addr_r <= wr_addr_r + ADDR_ONE;
                ovf_r     <= ovf_r | add_ovf_s;
                ce_b1_r   <= 1'b1;
            end else begin
                ce_b1_r   <= 1'b0;
            end
        end
    end

    assign idle_o    = idle_r;
    assign done_o    = done_r;
    assign ovf_o     = ovf_r;
    assign read_o    = ce_b0_r;
    assign ce_b0_o   = ce_b0_r;
    assign addr_b0_o = addr_b0_r;
    assign we_b0_o   = 1'b0;
    assign d_b0_o    = {(LANES*IN_W){1'b0}};
    assign write_o   = ce_b1_r;
    assign ce_b1_o   = ce_b1_r;
    assign we_b1_o   = ce_b1_r;
    assign addr_b1_o = addr_b1_r;
    assign d_b1_o    = d_b1_r;

endmodule
